pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer that generates the fetch address for the core.
//  Selects the next PC from four sources: sequential step, branch offset, jalr target and trap vector.
//  Captures redirects that arrive during a stall, checks target alignment, and runs a BOOT/RUN/HALT control FSM.
//  Sits between execute/control (redirect sources) and instruction fetch.
// PARAMETERS
//  XLEN          32            PC and target width
//  RESET_VECTOR  32'h0000_0000 PC loaded on reset
//  IALIGN        4             required target alignment in bytes; legal values 2 or 4
//  TRAP_VECTOR   32'h0000_0100 redirect target on misalignment (PC_TRAP_EN only)
// PORTS
//  i_clock           in   1     clock, rising edge
//  i_reset_n         in   1     asynchronous reset, active-low
//  i_advance         in   1     current instruction retired; step PC by 4
//  i_stall           in   1     hold PC; redirects are captured, not applied
//  i_branch          in   1     taken branch
//  i_branch_offset   in   XLEN  signed offset added to the current PC
//  i_jalr            in   1     register-indirect jump
//  i_jalr_target     in   XLEN  absolute target; bit 0 is cleared before use
//  i_halt            in   1     request to enter HALT
//  i_resume          in   1     leave HALT
//  o_pc              out  XLEN  current fetch PC
//  o_pc_valid        out  1     o_pc is valid for fetch (RUN state only)
//  o_state           out  2     FSM state: BOOT=0, RUN=1, HALT=2
//  o_misaligned      out  1     sticky misaligned-target flag
//  o_misaligned_addr out  XLEN  offending target captured with o_misaligned
//  o_epc             out  XLEN  PC of the faulting instruction (PC_TRAP_EN only)
// BEHAVIOUR
//  - Reset (async, i_reset_n=0): o_pc=RESET_VECTOR; state=BOOT; o_pc_valid=0.
//    All other outputs and the pending-redirect slot are cleared. Reset mid-operation discards everything.
//  - BOOT -> RUN on the first clock edge after reset is released. o_pc_valid=1 only in RUN.
//  - RUN priority per cycle: jalr > branch > advance. All arithmetic is mod 2^XLEN; wrap is silent.
//    jalr target = i_jalr_target & ~1. Branch target = o_pc + i_branch_offset. Step target = o_pc + 4.
//  - Stall: o_pc holds. A jalr or branch arriving while stalled is written to a one-deep pending slot.
//    If a second redirect arrives while the slot is full, the later one overwrites it. i_advance is ignored.
//  - First non-stalled cycle with the slot full: the pending target is applied and the slot cleared.
//    The pending target beats any new redirect that cycle; the new one is dropped.
//  - Misalignment: target[log2(IALIGN)-1:0] != 0, checked on jalr/branch targets only.
//    o_pc is not updated. o_misaligned=1 and o_misaligned_addr=target.
//  - i_halt in RUN: that cycle's PC update still occurs, then state -> HALT.
//  - HALT: o_pc_valid=0. Redirects and advance are ignored; the pending slot is retained.
//    i_resume -> RUN next cycle and clears o_misaligned. i_halt and i_resume together: halt wins.
//  - Latency: every PC change is visible on o_pc one cycle after the causing input is sampled.
// CONFIGURATION
//  PC_TRAP_EN defined:
//    Misalignment sets o_pc=TRAP_VECTOR and o_epc=the current o_pc; state stays RUN.
//    o_misaligned still sets. o_epc resets to 0.
//  PC_TRAP_EN undefined:
//    Misalignment forces state -> HALT (o_pc unchanged). o_epc is tied to 0.
// STRUCTURE
//  pc_pkg: pc_state_t enum {PC_BOOT, PC_RUN, PC_HALT}; redirect_kind_t {RD_NONE, RD_BRANCH, RD_JALR};
//          PC_STEP=4 constant.
//  Sub-module pc_target_calc: combinational target select/add, jalr LSB clear, alignment check.
//  Outputs: target, misaligned.
// TESTING
//  1 Reset release with RESET_VECTOR=0x1000: BOOT for 1 cycle with valid=0, then RUN with o_pc=0x1000, valid=1.
//    Three advances -> 0x1004, 0x1008, 0x100C.
//  2 PC=0x100, branch offset -8 together with jalr target 0x2001 -> o_pc=0x2000 (jalr wins, bit 0 cleared).
//    Branch alone from 0xFFFF_FFFC with offset 8 -> 0x0000_0004 (wrap).
//  3 Stall 3 cycles with branch(+0x20) then jalr(0x400) during the stall, PC=0x100: o_pc holds 0x100.
//    Stall drops -> o_pc=0x400 next cycle.
//  4 IALIGN=4, jalr target 0x302:
//    trap off -> HALT, o_pc unchanged, o_misaligned=1, addr=0x302; resume -> RUN with flag cleared.
//    trap on -> o_pc=0x100, o_epc=old PC.
//  5 i_halt with advance at PC=0x40 -> o_pc=0x44 and HALT. Advances and redirects ignored.
//    i_halt and i_resume together: stays HALT. i_resume alone -> RUN at 0x44.
//  6 Assert i_reset_n=0 mid-stall with a pending redirect -> immediate o_pc=RESET_VECTOR and BOOT.
//    After release the pending redirect is never applied.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
// No logic, so no latency.
// No handshake, so no backpressure.
package pc_pkg;

    // Control FSM states; the encoding is visible on o_state.
    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HALT = 2'd2
    } pc_state_t;

    // Source of a non-sequential PC change.
    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_BRANCH = 2'd1,
        RD_JALR   = 2'd2
    } redirect_kind_t;

    // Sequential fetch step in bytes.
    localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between execute/control (master) and the PC sequencer (slave).
// Wires only, so no latency.
// i_stall is the only hold signal; the other inputs are sampled once per cycle.
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            i_advance;
    logic            i_stall;
    logic            i_branch;
    logic [XLEN-1:0] i_branch_offset;
    logic            i_jalr;
    logic [XLEN-1:0] i_jalr_target;
    logic            i_halt;
    logic            i_resume;
    logic [XLEN-1:0] o_pc;
    logic            o_pc_valid;
    logic [1:0]      o_state;
    logic            o_misaligned;
    logic [XLEN-1:0] o_misaligned_addr;
    logic [XLEN-1:0] o_epc;

    // Execute/control side: drives requests, observes the PC.
    modport master (
        output i_advance, i_stall, i_branch, i_branch_offset,
        output i_jalr, i_jalr_target, i_halt, i_resume,
        input  o_pc, o_pc_valid, o_state, o_misaligned,
        input  o_misaligned_addr, o_epc
    );

    // Sequencer side.
    modport slave (
        input  i_advance, i_stall, i_branch, i_branch_offset,
        input  i_jalr, i_jalr_target, i_halt, i_resume,
        output o_pc, o_pc_valid, o_state, o_misaligned,
        output o_misaligned_addr, o_epc
    );
endinterface

// File: rtl/pc_target_calc.sv
// Picks the next-PC candidate (pending > jalr > branch > step) and checks its alignment.
// Purely combinational, zero latency.
// No backpressure; the caller gates pend_kind to RD_NONE while stalled.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 4
) (
    input  logic [XLEN-1:0] pc,
    input  redirect_kind_t  pend_kind,
    input  logic [XLEN-1:0] pend_target,
    input  logic            jalr,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_offset,
    output redirect_kind_t  kind,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] LSB_CLEAR  = ~XLEN'(1);

    // Priority select of the candidate target; adds wrap silently mod 2^XLEN.
    always_comb begin
        kind   = RD_NONE;
        target = pc + XLEN'(PC_STEP);
        if (pend_kind != RD_NONE) begin
            kind   = pend_kind;
            target = pend_target;
        end else if (jalr) begin
            kind   = RD_JALR;
            target = jalr_target & LSB_CLEAR;
        end else if (branch) begin
            kind   = RD_BRANCH;
            target = pc + branch_offset;
        end
    end

    // Sequential steps are aligned by construction; only redirects are checked.
    assign misaligned = (kind != RD_NONE) && ((target & ALIGN_MASK) != '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with BOOT/RUN/HALT control, stall-time redirect capture and alignment check.
// Every PC change appears on o_pc one cycle after the causing input is sampled.
// i_stall holds the PC and parks one redirect (latest wins); build with PC_TRAP_EN to trap instead of halting on misalignment.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 4,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    pc_sequencer_if.slave bus
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    redirect_kind_t  pend_kind_q, pend_kind_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] mis_addr_q, mis_addr_d;
`ifdef PC_TRAP_EN
    logic [XLEN-1:0] epc_q, epc_d;
`endif

    redirect_kind_t  calc_pend_kind;
    redirect_kind_t  calc_kind;
    logic [XLEN-1:0] calc_target;
    logic            calc_mis;

    // While stalled the calculator must expose the new redirect, not the parked one.
    assign calc_pend_kind = bus.i_stall ? RD_NONE : pend_kind_q;

    pc_target_calc #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_calc (
        .pc            (pc_q),
        .pend_kind     (calc_pend_kind),
        .pend_target   (pend_tgt_q),
        .jalr          (bus.i_jalr),
        .jalr_target   (bus.i_jalr_target),
        .branch        (bus.i_branch),
        .branch_offset (bus.i_branch_offset),
        .kind          (calc_kind),
        .target        (calc_target),
        .misaligned    (calc_mis)
    );

    // Next-state and next-datapath decision for the control FSM.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_kind_d = pend_kind_q;
        pend_tgt_d  = pend_tgt_q;
        mis_d       = mis_q;
        mis_addr_d  = mis_addr_q;
`ifdef PC_TRAP_EN
        epc_d       = epc_q;
`endif
        case (state_q)
            PC_BOOT: state_d = PC_RUN;
            PC_RUN: begin
                if (bus.i_stall) begin
                    // Park the redirect; a later one overwrites an earlier one.
                    if (calc_kind != RD_NONE) begin
                        pend_kind_d = calc_kind;
                        pend_tgt_d  = calc_target;
                    end
                end else begin
                    pend_kind_d = RD_NONE;
                    if (calc_mis) begin
                        mis_d      = 1'b1;
                        mis_addr_d = calc_target;
`ifdef PC_TRAP_EN
                        pc_d       = TRAP_VECTOR;
                        epc_d      = pc_q;
`else
                        state_d    = PC_HALT;
`endif
                    end else if ((calc_kind != RD_NONE) || bus.i_advance) begin
                        pc_d = calc_target;
                    end
                end
                // The update above still lands in the halting cycle.
                if (bus.i_halt) begin
                    state_d = PC_HALT;
                end
            end
            PC_HALT: begin
                if (bus.i_resume && !bus.i_halt) begin
                    state_d = PC_RUN;
                    mis_d   = 1'b0;
                end
            end
            default: state_d = PC_BOOT;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= PC_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, pending slot and fault-capture registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pc_q        <= RESET_VECTOR;
            pend_kind_q <= RD_NONE;
            pend_tgt_q  <= '0;
            mis_q       <= 1'b0;
            mis_addr_q  <= '0;
        end else begin
            pc_q        <= pc_d;
            pend_kind_q <= pend_kind_d;
            pend_tgt_q  <= pend_tgt_d;
            mis_q       <= mis_d;
            mis_addr_q  <= mis_addr_d;
        end
    end

`ifdef PC_TRAP_EN
    // Faulting-instruction PC, only kept when misalignment traps.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            epc_q <= '0;
        end else begin
            epc_q <= epc_d;
        end
    end
    assign bus.o_epc = epc_q;
`else
    assign bus.o_epc = '0;
`endif

    assign bus.o_pc              = pc_q;
    assign bus.o_pc_valid        = (state_q == PC_RUN);
    assign bus.o_state           = state_q;
    assign bus.o_misaligned      = mis_q;
    assign bus.o_misaligned_addr = mis_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset/boot, priority, wrap, stall capture, misalignment, halt, mid-run reset.
// Inputs change 1 ns after a rising edge; outputs are checked there too.
// Honours PC_TRAP_EN for the misalignment expectations.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_1000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic i_clock;
    logic i_reset_n;
    int   checks;
    int   failures;

    pc_sequencer_if #(.XLEN(32)) bus ();

    pc_sequencer #(
        .XLEN         (32),
        .RESET_VECTOR (RV),
        .IALIGN       (4),
        .TRAP_VECTOR  (TV)
    ) dut (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic idle();
        bus.i_advance       = 1'b0;
        bus.i_stall         = 1'b0;
        bus.i_branch        = 1'b0;
        bus.i_branch_offset = '0;
        bus.i_jalr          = 1'b0;
        bus.i_jalr_target   = '0;
        bus.i_halt          = 1'b0;
        bus.i_resume        = 1'b0;
    endtask

    task automatic jump(input logic [31:0] t);
        bus.i_jalr        = 1'b1;
        bus.i_jalr_target = t;
        tick();
        bus.i_jalr        = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        i_reset_n = 1'b0;
        idle();
        #12;
        // 1: reset and boot
        chk("rst_pc",    bus.o_pc, RV);
        chk("rst_state", bus.o_state, 2'd0);
        chk("rst_valid", bus.o_pc_valid, 1'b0);
        chk("rst_mis",   bus.o_misaligned, 1'b0);
        chk("rst_epc",   bus.o_epc, 32'h0);
        tick();
        i_reset_n = 1'b1;
        chk("boot_state", bus.o_state, 2'd0);
        chk("boot_valid", bus.o_pc_valid, 1'b0);
        tick();
        chk("run_state", bus.o_state, 2'd1);
        chk("run_valid", bus.o_pc_valid, 1'b1);
        chk("run_pc",    bus.o_pc, RV);
        bus.i_advance = 1'b1;
        tick(); chk("adv1", bus.o_pc, 32'h1004);
        tick(); chk("adv2", bus.o_pc, 32'h1008);
        tick(); chk("adv3", bus.o_pc, 32'h100C);
        bus.i_advance = 1'b0;
        tick(); chk("noadv_hold", bus.o_pc, 32'h100C);

        // 2: priority and wrap
        jump(32'h100);
        chk("jalr_100", bus.o_pc, 32'h100);
        bus.i_branch        = 1'b1;
        bus.i_branch_offset = 32'hFFFF_FFF8;
        bus.i_advance       = 1'b1;
        jump(32'h2001);
        chk("jalr_wins", bus.o_pc, 32'h2000);
        bus.i_advance = 1'b0;
        tick();
        chk("branch_neg", bus.o_pc, 32'h1FF8);
        bus.i_branch = 1'b0;
        jump(32'hFFFF_FFFC);
        bus.i_branch        = 1'b1;
        bus.i_branch_offset = 32'h8;
        tick();
        bus.i_branch = 1'b0;
        chk("branch_wrap", bus.o_pc, 32'h4);

        // 3: stall captures redirects, latest wins, pending beats new
        jump(32'h100);
        bus.i_stall         = 1'b1;
        bus.i_branch        = 1'b1;
        bus.i_branch_offset = 32'h20;
        tick(); chk("stall1", bus.o_pc, 32'h100);
        bus.i_branch = 1'b0;
        jump(32'h400);
        chk("stall2", bus.o_pc, 32'h100);
        bus.i_advance = 1'b1;
        tick(); chk("stall3", bus.o_pc, 32'h100);
        bus.i_advance       = 1'b0;
        bus.i_stall         = 1'b0;
        bus.i_branch        = 1'b1;
        bus.i_branch_offset = 32'h40;
        tick(); chk("pend_apply", bus.o_pc, 32'h400);
        bus.i_branch = 1'b0;
        tick(); chk("pend_clear", bus.o_pc, 32'h400);

        // 4: misaligned jalr target
        jump(32'h200);
        jump(32'h302);
        chk("mis_flag", bus.o_misaligned, 1'b1);
        chk("mis_addr", bus.o_misaligned_addr, 32'h302);
`ifdef PC_TRAP_EN
        chk("trap_pc",    bus.o_pc, TV);
        chk("trap_epc",   bus.o_epc, 32'h200);
        chk("trap_state", bus.o_state, 2'd1);
`else
        chk("mis_pc",    bus.o_pc, 32'h200);
        chk("mis_state", bus.o_state, 2'd2);
        chk("mis_valid", bus.o_pc_valid, 1'b0);
        chk("mis_epc",   bus.o_epc, 32'h0);
        bus.i_resume = 1'b1;
        tick();
        bus.i_resume = 1'b0;
        chk("resume_state", bus.o_state, 2'd1);
        chk("resume_mis",   bus.o_misaligned, 1'b0);
`endif

        // 5: halt
        jump(32'h40);
        bus.i_halt    = 1'b1;
        bus.i_advance = 1'b1;
        tick();
        chk("halt_pc",    bus.o_pc, 32'h44);
        chk("halt_state", bus.o_state, 2'd2);
        chk("halt_valid", bus.o_pc_valid, 1'b0);
        bus.i_halt = 1'b0;
        jump(32'h800);
        chk("halt_ignore", bus.o_pc, 32'h44);
        bus.i_advance = 1'b0;
        bus.i_halt    = 1'b1;
        bus.i_resume  = 1'b1;
        tick(); chk("halt_wins", bus.o_state, 2'd2);
        bus.i_halt = 1'b0;
        tick();
        bus.i_resume = 1'b0;
        chk("resume2_state", bus.o_state, 2'd1);
        chk("resume2_pc",    bus.o_pc, 32'h44);
        chk("resume2_mis",   bus.o_misaligned, 1'b0);

        // 6: reset mid-stall discards the pending redirect
        bus.i_stall = 1'b1;
        jump(32'h600);
        chk("stall_pend", bus.o_pc, 32'h44);
        #2 i_reset_n = 1'b0;
        #1;
        chk("mid_rst_pc",    bus.o_pc, RV);
        chk("mid_rst_state", bus.o_state, 2'd0);
        bus.i_stall = 1'b0;
        tick();
        i_reset_n = 1'b1;
        tick();
        chk("rerun_pc",    bus.o_pc, RV);
        chk("rerun_state", bus.o_state, 2'd1);
        tick();
        chk("no_stale_pend", bus.o_pc, RV);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
